// File: rtl/usb_fs_in_pe.sv
// ---------------------------------------------------------------------------
// usb_fs_in_pe -- USB full-speed IN protocol engine.
//
// Answers IN tokens with the committed packet of the addressed endpoint
// (DATA0/DATA1), with NAK when nothing is committed, or with STALL. Each
// endpoint owns one single-packet buffer that the application fills through
// the put bus. The packet is released (buffer freed, toggle flipped) only
// when the host ACKs it. A missing or bad handshake leaves the packet in
// place, so the next IN resends identical data.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   reset_ep                per-endpoint synchronous clear
//   dev_addr                assigned device address
//   in_ep_grant/_data_put   put bus: owner select and write strobe
//   in_ep_data/_data_done   write byte and packet commit
//   in_ep_data_free         endpoint accepts puts
//   in_ep_stall             level, forces the endpoint to STALL
//   in_ep_acked             1-cycle pulse when the host ACKs a packet
//   rx_*                    fields and strobes of the last received packet
//   tx_pkt_start/tx_pid     start strobe and PID of the response
//   tx_pkt_end              transmit complete strobe
//   tx_data_avail/_get/tx_data  payload byte stream towards the tx layer
// ---------------------------------------------------------------------------
module usb_fs_in_pe #(
  parameter int NUM_IN_EPS         = 1,
  parameter int MAX_IN_PACKET_SIZE = 32,
  parameter int ACK_TIMEOUT        = 640
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_IN_EPS-1:0] reset_ep,
  input  logic [6:0]            dev_addr,
  input  logic [NUM_IN_EPS-1:0] in_ep_grant,
  input  logic [NUM_IN_EPS-1:0] in_ep_data_put,
  input  logic [7:0]            in_ep_data,
  input  logic [NUM_IN_EPS-1:0] in_ep_data_done,
  output logic [NUM_IN_EPS-1:0] in_ep_data_free,
  input  logic [NUM_IN_EPS-1:0] in_ep_stall,
  output logic [NUM_IN_EPS-1:0] in_ep_acked,
  input  logic                  rx_pkt_start,
  input  logic                  rx_pkt_end,
  input  logic                  rx_pkt_valid,
  input  logic [3:0]            rx_pid,
  input  logic [6:0]            rx_addr,
  input  logic [3:0]            rx_endp,
  output logic                  tx_pkt_start,
  output logic [3:0]            tx_pid,
  input  logic                  tx_pkt_end,
  output logic                  tx_data_avail,
  input  logic                  tx_data_get,
  output logic [7:0]            tx_data
);

  localparam int AW  = $clog2(MAX_IN_PACKET_SIZE);
  localparam int PW  = AW + 1;                       // counts 0..MAX inclusive
  localparam int EPW = (NUM_IN_EPS > 1) ? $clog2(NUM_IN_EPS) : 1;
  localparam int BW  = $clog2(NUM_IN_EPS * MAX_IN_PACKET_SIZE);
  localparam int TW  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  typedef enum logic [1:0] {EP_READY, EP_PKT_READY, EP_STALL} ep_state_e;
  typedef enum logic [1:0] {X_IDLE, X_RCVD_IN, X_SEND_DATA, X_WAIT_HS} xfr_state_e;

  // The start-of-packet strobe carries no information this engine needs.
  logic unused_rx_pkt_start;
  assign unused_rx_pkt_start = rx_pkt_start;

  // Buffer address of endpoint ep, byte addr. MAX is a power of two, so
  // ep*MAX + addr is a plain concatenation.
  function automatic logic [BW-1:0] buf_idx(input logic [EPW-1:0] ep,
                                            input logic [AW-1:0]  addr);
    return BW'({ep, addr});
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  ep_state_e             ep_state_q [NUM_IN_EPS];
  ep_state_e             ep_state_d [NUM_IN_EPS];
  logic [PW-1:0]         put_addr_q [NUM_IN_EPS];
  logic [PW-1:0]         put_addr_d [NUM_IN_EPS];
  logic [NUM_IN_EPS-1:0] toggle_q, toggle_d;
  logic [NUM_IN_EPS-1:0] buf_we;

  xfr_state_e            xfr_q, xfr_d;
  logic [EPW-1:0]        cur_ep_q, cur_ep_d;
  logic [PW-1:0]         get_addr_q, get_addr_d;
  logic [TW-1:0]         timeout_q, timeout_d;
  logic                  tx_start_q, tx_start_d;
  logic [3:0]            tx_pid_q, tx_pid_d;
  logic [NUM_IN_EPS-1:0] acked_q, acked_d;
  logic                  ack_evt;

  logic [7:0]            buf_mem [NUM_IN_EPS*MAX_IN_PACKET_SIZE];

  // ---------------------------------------------------------------------
  // Token decode
  // ---------------------------------------------------------------------
  logic           tok_ok, in_token, setup_token, ack_rx;
  logic [EPW-1:0] tok_ep;

  assign tok_ok      = rx_pkt_end && rx_pkt_valid && (rx_pid[1:0] == 2'b01) &&
                       (rx_addr == dev_addr) && (int'(rx_endp) < NUM_IN_EPS);
  assign in_token    = tok_ok && (rx_pid == PID_IN);
  assign setup_token = tok_ok && (rx_pid == PID_SETUP);
  assign ack_rx      = rx_pkt_end && rx_pkt_valid && (rx_pid == PID_ACK);
  assign tok_ep      = rx_endp[EPW-1:0];

  // ---------------------------------------------------------------------
  // Endpoint FSMs
  // ---------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    toggle_d = toggle_q;
    buf_we   = '0;
    for (int e = 0; e < NUM_IN_EPS; e++) begin
      logic ack_here, setup_here;
      ack_here      = ack_evt && (int'(cur_ep_q) == e);
      setup_here    = setup_token && (int'(tok_ep) == e);
      ep_state_d[e] = ep_state_q[e];
      put_addr_d[e] = put_addr_q[e];

      if (reset_ep[e]) begin
        ep_state_d[e] = EP_READY;
        put_addr_d[e] = '0;
        toggle_d[e]   = 1'b0;
      end else begin
        unique case (ep_state_q[e])
          EP_READY: begin
            // Puts past the end of the buffer are dropped.
            if (in_ep_grant[e] && in_ep_data_put[e] &&
                (put_addr_q[e] < PW'(MAX_IN_PACKET_SIZE))) begin
              buf_we[e]     = 1'b1;
              put_addr_d[e] = put_addr_q[e] + 1'b1;
            end
            if (in_ep_grant[e] && in_ep_data_done[e]) ep_state_d[e] = EP_PKT_READY;
          end
          EP_PKT_READY: begin
            if (ack_here) begin
              ep_state_d[e] = EP_READY;
              put_addr_d[e] = '0;
            end
          end
          EP_STALL: begin
            // Leaving STALL discards whatever was half-written before it.
            if (setup_here && !in_ep_stall[e]) begin
              ep_state_d[e] = EP_READY;
              put_addr_d[e] = '0;
            end
          end
          default: ep_state_d[e] = EP_READY;
        endcase

        if (setup_here)    toggle_d[e] = 1'b1;
        else if (ack_here) toggle_d[e] = ~toggle_q[e];

        // A stall raised mid-transfer lets the packet finish on the wire but
        // parks the endpoint here, so the eventual ACK cannot release it.
        if (in_ep_stall[e]) ep_state_d[e] = EP_STALL;
      end
    end
  end

  for (genvar g = 0; g < NUM_IN_EPS; g++) begin : g_free
    assign in_ep_data_free[g] = (ep_state_q[g] == EP_READY) &&
                                (put_addr_q[g] < PW'(MAX_IN_PACKET_SIZE));
  end

  // ---------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------
  always_comb begin
    xfr_d      = xfr_q;
    cur_ep_d   = cur_ep_q;
    get_addr_d = get_addr_q;
    timeout_d  = timeout_q;
    tx_start_d = 1'b0;
    tx_pid_d   = tx_pid_q;
    acked_d    = '0;
    ack_evt    = 1'b0;

    unique case (xfr_q)
      X_IDLE: begin
        if (in_token) begin
          cur_ep_d = tok_ep;
          xfr_d    = X_RCVD_IN;
        end
      end
      X_RCVD_IN: begin
        // Start/PID are registered, which places the response two cycles
        // after the token's rx_pkt_end.
        tx_start_d = 1'b1;
        unique case (ep_state_q[cur_ep_q])
          EP_STALL: begin
            tx_pid_d = PID_STALL;
            xfr_d    = X_IDLE;
          end
          EP_PKT_READY: begin
            tx_pid_d   = toggle_q[cur_ep_q] ? PID_DATA1 : PID_DATA0;
            get_addr_d = '0;
            xfr_d      = X_SEND_DATA;
          end
          default: begin
            tx_pid_d = PID_NAK;
            xfr_d    = X_IDLE;
          end
        endcase
      end
      X_SEND_DATA: begin
        if (tx_data_get && tx_data_avail) get_addr_d = get_addr_q + 1'b1;
        if (tx_pkt_end) begin
          timeout_d = '0;
          xfr_d     = X_WAIT_HS;
        end
      end
      X_WAIT_HS: begin
        if (rx_pkt_end) begin
          if (ack_rx) begin
            ack_evt           = 1'b1;
            acked_d[cur_ep_q] = 1'b1;
          end
          xfr_d = X_IDLE;
        end else if (timeout_q == TW'(ACK_TIMEOUT - 1)) begin
          xfr_d = X_IDLE;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end
      default: xfr_d = X_IDLE;
    endcase

    if (reset_ep[cur_ep_q]) get_addr_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < NUM_IN_EPS; e++) begin
        ep_state_q[e] <= EP_READY;
        put_addr_q[e] <= '0;
      end
      toggle_q   <= '0;
      xfr_q      <= X_IDLE;
      cur_ep_q   <= '0;
      get_addr_q <= '0;
      timeout_q  <= '0;
      tx_start_q <= 1'b0;
      tx_pid_q   <= '0;
      acked_q    <= '0;
    end else begin
      for (int e = 0; e < NUM_IN_EPS; e++) begin
        ep_state_q[e] <= ep_state_d[e];
        put_addr_q[e] <= put_addr_d[e];
      end
      toggle_q   <= toggle_d;
      xfr_q      <= xfr_d;
      cur_ep_q   <= cur_ep_d;
      get_addr_q <= get_addr_d;
      timeout_q  <= timeout_d;
      tx_start_q <= tx_start_d;
      tx_pid_q   <= tx_pid_d;
      acked_q    <= acked_d;
    end
  end

  // NOTE: the packet buffer has no reset; its contents are only ever read
  // below put_addr, which reset clears, so stale bytes are never visible.
  always_ff @(posedge clk) begin
    for (int e = 0; e < NUM_IN_EPS; e++) begin
      if (buf_we[e]) buf_mem[buf_idx(EPW'(e), put_addr_q[e][AW-1:0])] <= in_ep_data;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign tx_pkt_start  = tx_start_q;
  assign tx_pid        = tx_pid_q;
  assign in_ep_acked   = acked_q;
  assign tx_data_avail = (xfr_q == X_SEND_DATA) && (get_addr_q < put_addr_q[cur_ep_q]);
  // Driven to zero whenever no byte is pending so the bus is quiet at reset.
  assign tx_data       = tx_data_avail ? buf_mem[buf_idx(cur_ep_q, get_addr_q[AW-1:0])]
                                       : 8'h00;

endmodule
